// File: rtl/neopixel_rx_fsm.sv
// rtl/neopixel_rx_fsm.sv - NeoPixel serial line receiver FSM
//
// Purpose: decodes the single-wire NeoPixel protocol into 24-bit GRB words
// and reset messages. A word or reset message is written to a downstream FIFO.
// Each bit is classified by measuring its high time. A reset message is
// recognised by a long low time.
//
// Ports:
//   clk        in   20 MHz clock
//   rst        in   asynchronous active-low reset
//   mode       in   1 = 800 kHz, 0 = 400 kHz bit timing
//   rx_enable  in   receive enable; low forces the receiver idle
//   neo_rx_in  in   asynchronous serial line
//   full_flg   in   downstream FIFO full
//   wr_next    out  FIFO write strobe, one cycle
//   neo_dOut   out  received word, first bit received in bit 23
//   rgb_msgTyp out  1 = color word, 0 = reset message
//   frame_err  out  one-cycle pulse on a malformed frame
//   overflow   out  sticky: a write was dropped because the FIFO was full
module neopixel_rx_fsm #(
   parameter logic [10:0] RST_CYCLES = 11'd1000,
   parameter logic [5:0]  THR800     = 6'd12,
   parameter logic [5:0]  THR400     = 6'd17,
   parameter logic [5:0]  HI_MAX     = 6'd40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode,
   input  logic        rx_enable,
   input  logic        neo_rx_in,
   input  logic        full_flg,
   output logic        wr_next,
   output logic [23:0] neo_dOut,
   output logic        rgb_msgTyp,
   output logic        frame_err,
   output logic        overflow
);

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      MEAS_HI  = 2'd1,
      MEAS_LO  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;

   logic        r_sync1, r_sync2;
   logic [10:0] r_lo_cnt, w_lo_cnt_nxt;
   logic [5:0]  r_hi_cnt, w_hi_cnt_nxt;
   logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [23:0] r_shift, w_shift_nxt;

   logic        r_wr_next, w_wr_next_nxt;
   logic [23:0] r_dout, w_dout_nxt;
   logic        r_msg_typ, w_msg_typ_nxt;
   logic        r_frame_err, w_frame_err_nxt;
   logic        r_overflow, w_overflow_nxt;

   logic        w_s;
   logic [10:0] w_lo_inc;
   logic [5:0]  w_hi_inc;
   logic [5:0]  w_thr;
   logic        w_bit;
   logic [23:0] w_shift_in;
   logic        w_emit;
   logic [23:0] w_emit_word;
   logic        w_emit_typ;

   assign w_s        = r_sync2;
   // Both counters saturate instead of wrapping, so a very long low or high
   // never looks like a short one.
   assign w_lo_inc   = (r_lo_cnt >= RST_CYCLES) ? RST_CYCLES : r_lo_cnt + 11'd1;
   assign w_hi_inc   = (r_hi_cnt == 6'h3F) ? 6'h3F : r_hi_cnt + 6'd1;
   // Mode is looked at only when a bit is decided, so switching mid-word
   // affects only the bits that follow.
   assign w_thr      = mode ? THR800 : THR400;
   assign w_bit      = (r_hi_cnt >= w_thr);
   assign w_shift_in = {r_shift[22:0], w_bit};

   always_comb begin
      w_state_nxt     = r_state;
      w_lo_cnt_nxt    = r_lo_cnt;
      w_hi_cnt_nxt    = r_hi_cnt;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_wr_next_nxt   = 1'b0;
      w_dout_nxt      = r_dout;
      w_msg_typ_nxt   = r_msg_typ;
      w_frame_err_nxt = 1'b0;
      w_overflow_nxt  = r_overflow;
      w_emit          = 1'b0;
      w_emit_word     = 24'h0;
      w_emit_typ      = 1'b0;

      if (!rx_enable) begin
         w_state_nxt   = WAIT_LOW;
         w_lo_cnt_nxt  = 11'd0;
         w_hi_cnt_nxt  = 6'd0;
         w_bit_cnt_nxt = 5'd0;
         w_shift_nxt   = 24'h0;
      end else begin
         case (r_state)
            WAIT_LOW: begin
               w_hi_cnt_nxt  = 6'd0;
               w_bit_cnt_nxt = 5'd0;
               w_shift_nxt   = 24'h0;
               if (w_s) begin
                  w_lo_cnt_nxt = 11'd0;
               end else begin
                  w_lo_cnt_nxt = w_lo_inc;
                  // The low counter is left saturated on exit. MEAS_LO then
                  // does not report this same low period as a reset message.
                  if (w_lo_inc == RST_CYCLES) begin
                     w_state_nxt = MEAS_LO;
                  end
               end
            end

            MEAS_LO: begin
               if (w_s) begin
                  w_hi_cnt_nxt = 6'd0;
                  w_state_nxt  = MEAS_HI;
               end else begin
                  w_lo_cnt_nxt = w_lo_inc;
                  // The counter stays saturated until the next falling edge.
                  // Only the first arrival counts, so one low period gives
                  // at most one reset message.
                  if ((w_lo_inc == RST_CYCLES) && (r_lo_cnt != RST_CYCLES)) begin
                     if (r_bit_cnt != 5'd0) begin
                        w_frame_err_nxt = 1'b1;
                     end
                     w_bit_cnt_nxt = 5'd0;
                     w_shift_nxt   = 24'h0;
                     w_emit        = 1'b1;
                     w_emit_word   = 24'h0;
                     w_emit_typ    = 1'b0;
                  end
               end
            end

            MEAS_HI: begin
               if (!w_s) begin
                  w_lo_cnt_nxt = 11'd0;
                  w_state_nxt  = MEAS_LO;
                  if (r_bit_cnt == 5'd23) begin
                     w_bit_cnt_nxt = 5'd0;
                     w_shift_nxt   = 24'h0;
                     w_emit        = 1'b1;
                     w_emit_word   = w_shift_in;
                     w_emit_typ    = 1'b1;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                     w_shift_nxt   = w_shift_in;
                  end
               end else if (r_hi_cnt > HI_MAX) begin
                  // A stuck-high line gives no usable bit. Drop the word and
                  // wait for a clean reset-length low before decoding again.
                  w_frame_err_nxt = 1'b1;
                  w_bit_cnt_nxt   = 5'd0;
                  w_shift_nxt     = 24'h0;
                  w_hi_cnt_nxt    = 6'd0;
                  w_lo_cnt_nxt    = 11'd0;
                  w_state_nxt     = WAIT_LOW;
               end else begin
                  w_hi_cnt_nxt = w_hi_inc;
               end
            end

            default: begin
               w_state_nxt = WAIT_LOW;
            end
         endcase
      end

      // A message the FIFO cannot accept is dropped. The outputs keep the
      // last value that was actually written.
      if (w_emit) begin
         if (full_flg) begin
            w_overflow_nxt = 1'b1;
         end else begin
            w_wr_next_nxt = 1'b1;
            w_dout_nxt    = w_emit_word;
            w_msg_typ_nxt = w_emit_typ;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_state     <= WAIT_LOW;
         r_lo_cnt    <= 11'd0;
         r_hi_cnt    <= 6'd0;
         r_bit_cnt   <= 5'd0;
         r_shift     <= 24'h0;
         r_wr_next   <= 1'b0;
         r_dout      <= 24'h0;
         r_msg_typ   <= 1'b0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_sync1     <= neo_rx_in;
         r_sync2     <= r_sync1;
         r_state     <= w_state_nxt;
         r_lo_cnt    <= w_lo_cnt_nxt;
         r_hi_cnt    <= w_hi_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_wr_next   <= w_wr_next_nxt;
         r_dout      <= w_dout_nxt;
         r_msg_typ   <= w_msg_typ_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_overflow  <= w_overflow_nxt;
      end
   end

   assign wr_next    = r_wr_next;
   assign neo_dOut   = r_dout;
   assign rgb_msgTyp = r_msg_typ;
   assign frame_err  = r_frame_err;
   assign overflow   = r_overflow;

endmodule
